// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder stage.
// Imported by serial_adder; the optional overflow output is enabled by SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell; the serial adder time-multiplexes one instance over all bits.
module serial_adder_full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule : serial_adder_full_adder

// File: rtl/serial_adder.sv
// Bit-serial adder: one full adder, LSB first, registered carry, start/done handshake.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output o_ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             o_ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             carry_q,  carry_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q,    ovf_d;
`endif

    logic fa_sum;
    logic fa_cout;
    logic load_op;

    serial_adder_full_adder u_full_adder (
        .i_a    (a_sr_q[0]),
        .i_b    (b_sr_q[0]),
        .i_cin  (carry_q),
        .o_sum  (fa_sum),
        .o_cout (fa_cout)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        count_d  = count_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d    = ovf_q;
`endif
        load_op  = 1'b0;

        unique case (state_q)
            IDLE: begin
                load_op = i_start;
            end
            RUN: begin
                sum_sr_d           = sum_sr_q >> 1;
                sum_sr_d[WIDTH-1]  = fa_sum;
                carry_d            = fa_cout;
                a_sr_d             = a_sr_q >> 1;
                b_sr_d             = b_sr_q >> 1;
                count_d            = count_q + CNT_W'(1);
                // Final bit: publish the assembled sum so outputs never show partial results.
                if (count_q == LAST_BIT) begin
                    state_d = DONE;
                    sum_d   = sum_sr_d;
                    cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = carry_q ^ fa_cout;
`endif
                end
            end
            DONE: begin
                load_op = i_start;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Start is honoured from IDLE and DONE alike, which gives back-to-back operation.
        if (load_op) begin
            state_d = RUN;
            a_sr_d  = i_a;
            b_sr_d  = i_b;
            carry_d = i_cin;
            count_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            count_q  <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            count_q  <= count_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign o_busy = (state_q == RUN);
    assign o_done = (state_q == DONE);
    assign o_sum  = sum_q;
    assign o_cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign o_ovf  = ovf_q;
`endif

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8); covers o_ovf when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

    logic       i_clk;
    logic       i_rst;
    logic       i_start;
    logic [7:0] i_a;
    logic [7:0] i_b;
    logic       i_cin;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_sum;
    logic       o_cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic       o_ovf;
    logic       prev_ovf;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0] prev_sum;
    logic       prev_cout;

    serial_adder #(.WIDTH(8)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_cin   (i_cin),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_sum   (o_sum),
        .o_cout  (o_cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .o_ovf   (o_ovf)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs must hold the last published result while not in DONE.
    task automatic chk_hold(input string tag);
        chk({tag, " sum hold"}, 9'(o_sum), 9'(prev_sum));
        chk({tag, " cout hold"}, 9'(o_cout), 9'(prev_cout));
`ifdef SERIAL_ADDER_OVF_EN
        chk({tag, " ovf hold"}, 9'(o_ovf), 9'(prev_ovf));
`endif
    endtask

    task automatic idle(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge i_clk);
            chk({tag, " idle busy"}, 9'(o_busy), 9'd0);
            chk({tag, " idle done"}, 9'(o_done), 9'd0);
            chk_hold(tag);
        end
    endtask

    // Called at a negedge; drives start now, checks cycles 1..9, returns at the DONE negedge.
    // inj_cyc != 0 pulses a bogus start (0xFF+0xFF+1) during that RUN cycle.
    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic [7:0] exp_sum, input logic exp_cout,
                         input int inj_cyc);
        i_start = 1'b1;
        i_a     = a;
        i_b     = b;
        i_cin   = cin;
        for (int c = 1; c <= 9; c++) begin
            @(negedge i_clk);
            if (c == 1 || c == inj_cyc + 1) i_start = 1'b0;
            chk({tag, " busy"}, 9'(o_busy), 9'(c <= 8));
            chk({tag, " done"}, 9'(o_done), 9'(c == 9));
            if (c < 9) begin
                chk_hold(tag);
            end else begin
                chk({tag, " sum"}, 9'(o_sum), 9'(exp_sum));
                chk({tag, " cout"}, 9'(o_cout), 9'(exp_cout));
                prev_sum  = exp_sum;
                prev_cout = exp_cout;
`ifdef SERIAL_ADDER_OVF_EN
                prev_ovf = (a[7] == b[7]) && (exp_sum[7] != a[7]);
                chk({tag, " ovf"}, 9'(o_ovf), 9'(prev_ovf));
`endif
            end
            if (c == inj_cyc) begin
                i_start = 1'b1;
                i_a     = 8'hFF;
                i_b     = 8'hFF;
                i_cin   = 1'b1;
            end
        end
    endtask

    initial begin
        i_rst     = 1'b1;
        i_start   = 1'b0;
        i_a       = 8'h00;
        i_b       = 8'h00;
        i_cin     = 1'b0;
        prev_sum  = 8'h00;
        prev_cout = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
        prev_ovf  = 1'b0;
`endif

        repeat (2) @(negedge i_clk);
        chk("reset busy", 9'(o_busy), 9'd0);
        chk("reset done", 9'(o_done), 9'd0);
        chk_hold("reset");
        i_rst = 1'b0;

        do_op("5a+3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0);
        idle("after 5a+3c", 2);
        do_op("ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
        idle("after ff+01", 1);
        do_op("ff+00+1", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 0);
        idle("after ff+00+1", 1);
        do_op("12+34 ign start", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 4);
        idle("after ign start", 1);

        // Reset during RUN: abort with no done, outputs cleared.
        i_start = 1'b1;
        i_a     = 8'hAA;
        i_b     = 8'h55;
        i_cin   = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            chk("abort busy", 9'(o_busy), 9'd1);
        end
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst     = 1'b0;
        prev_sum  = 8'h00;
        prev_cout = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
        prev_ovf  = 1'b0;
`endif
        chk("abort busy cleared", 9'(o_busy), 9'd0);
        chk("abort no done", 9'(o_done), 9'd0);
        chk_hold("abort");
        idle("after abort", 10);
        do_op("01+01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0);

        // Second start lands in the DONE cycle of the first: no IDLE gap.
        idle("before b2b", 1);
        do_op("b2b first 33+44", 8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 0);
        do_op("b2b second 10+20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 0);
        idle("after b2b", 1);

`ifdef SERIAL_ADDER_OVF_EN
        do_op("ovf 7f+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 0);
        idle("after ovf 7f+01", 1);
        do_op("ovf 80+80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0);
        idle("after ovf 80+80", 1);
        do_op("ovf 05+03", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 0);
        idle("after ovf 05+03", 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_adder
